// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

    // Controller states; the numeric values are visible on state_o.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Winning button action in one cycle, after priority resolution (clear is handled apart).
    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_STOP  = 2'd1,
        ACT_LAP   = 2'd2,
        ACT_START = 2'd3
    } act_t;

    // Bit positions of each button in the edge-detector vector.
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LAP   = 2;
    localparam int BTN_CLEAR = 3;
    localparam int NUM_BTN   = 4;

    // Prescaler width: max(1, clog2(div)).
    function automatic int pre_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge (press) detector for a vector of debounced button levels.
// The sample register resets to ones so a button held through reset is
// not seen as a press until it is released and pressed again.
module btn_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    output logic [W-1:0] press
);

    logic [W-1:0] x_q;

    // Previous-cycle sample of every button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) x_q <= '1;
        else     x_q <= x;
    end

    assign press = x & ~x_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/done FSM, time-base prescaler,
// elapsed/remaining counter, lap snapshot and display select.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter int          TICK_DIV   = 1000,
    parameter int          COUNT_DOWN = 0,
    parameter int unsigned MAX_COUNT  = (1 << CNT_W) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             lap,
    input  logic             clear,
    input  logic [CNT_W-1:0] preset,
    output logic             en,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] disp,
    output logic             tick,
    output logic             done,
    output logic [2:0]       state_o
);

    localparam int               PRE_W    = pre_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               DOWN     = (COUNT_DOWN != 0);

    state_t           state, state_nxt;
    act_t             act;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] lap_q;
    logic [NUM_BTN-1:0] btn_lvl, btn_press;
    logic             press_clear;
    logic             term;
    logic             snap;

    assign btn_lvl[BTN_START] = start;
    assign btn_lvl[BTN_STOP]  = stop;
    assign btn_lvl[BTN_LAP]   = lap;
    assign btn_lvl[BTN_CLEAR] = clear;

    btn_edge #(.W(NUM_BTN)) u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .x     (btn_lvl),
        .press (btn_press)
    );

    assign press_clear = btn_press[BTN_CLEAR];

    // Register decodes; no output has a combinational path from a button.
    assign en      = (state == S_RUN) || (state == S_LAP);
    assign tick    = en && (pre == PRE_LAST);
    assign term    = DOWN && tick && (count == CNT_ONE);
    assign disp    = (state == S_LAP) ? lap_q : count;
    assign done    = (state == S_DONE);
    assign state_o = state;

    // Resolve simultaneous presses to a single action: start+stop cancels everything.
    always_comb begin
        act = ACT_NONE;
        if (btn_press[BTN_START] && btn_press[BTN_STOP]) act = ACT_NONE;
        else if (btn_press[BTN_STOP])                    act = ACT_STOP;
        else if (btn_press[BTN_LAP])                     act = ACT_LAP;
        else if (btn_press[BTN_START])                   act = ACT_START;
    end

    // Next-state logic; the countdown terminal step outranks stop/lap so the
    // controller can never sit outside DONE with a zero countdown.
    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        if (press_clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (act == ACT_START)
                        state_nxt = (DOWN && count == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (term)                  state_nxt = S_DONE;
                    else if (act == ACT_STOP)  state_nxt = S_PAUSE;
                    else if (act == ACT_LAP) begin
                        state_nxt = S_LAP;
                        snap      = 1'b1;
                    end
                end
                S_LAP: begin
                    if (term)                  state_nxt = S_DONE;
                    else if (act == ACT_STOP)  state_nxt = S_PAUSE;
                    else if (act == ACT_LAP)   state_nxt = S_RUN;
                end
                S_PAUSE: begin
                    if (act == ACT_START)      state_nxt = S_RUN;
                end
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Prescaler: advances only while enabled, so a pause keeps the partial tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              pre <= '0;
        else if (press_clear) pre <= '0;
        else if (en)          pre <= tick ? '0 : pre + PRE_ONE;
    end

    // Elapsed/remaining counter: loads on clear, steps on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              count <= '0;
        else if (press_clear) count <= DOWN ? preset : '0;
        else if (tick) begin
            if (DOWN)                  count <= count - CNT_ONE;
            else if (count == CNT_MAX) count <= '0;
            else                       count <= count + CNT_ONE;
        end
    end

    // Lap snapshot taken when RUN hands over to LAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       lap_q <= '0;
        else if (snap) lap_q <= count;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: an up-counting and a down-counting instance run
// side by side against a flag-based reference model checked every cycle.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int W      = 8;
    localparam int DIV_UP = 4;
    localparam int DIV_DN = 2;
    localparam int MAXC   = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   btn     [2];
    logic [W-1:0] preset  [2];
    logic         en_w    [2];
    logic         tick_w  [2];
    logic         done_w  [2];
    logic [W-1:0] count_w [2];
    logic [W-1:0] disp_w  [2];
    logic [2:0]   st_w    [2];

    stopwatch_ctrl #(.CNT_W(W), .TICK_DIV(DIV_UP), .COUNT_DOWN(0), .MAX_COUNT(MAXC)) dut_up (
        .clk(clk), .rst(rst),
        .start(btn[0][BTN_START]), .stop(btn[0][BTN_STOP]),
        .lap(btn[0][BTN_LAP]), .clear(btn[0][BTN_CLEAR]),
        .preset(preset[0]), .en(en_w[0]), .count(count_w[0]), .disp(disp_w[0]),
        .tick(tick_w[0]), .done(done_w[0]), .state_o(st_w[0])
    );

    stopwatch_ctrl #(.CNT_W(W), .TICK_DIV(DIV_DN), .COUNT_DOWN(1)) dut_dn (
        .clk(clk), .rst(rst),
        .start(btn[1][BTN_START]), .stop(btn[1][BTN_STOP]),
        .lap(btn[1][BTN_LAP]), .clear(btn[1][BTN_CLEAR]),
        .preset(preset[1]), .en(en_w[1]), .count(count_w[1]), .disp(disp_w[1]),
        .tick(tick_w[1]), .done(done_w[1]), .state_o(st_w[1])
    );

    // ---------------- reference model ----------------
    bit m_run [2], m_lap [2], m_pause [2], m_done [2];
    int m_cnt [2], m_pre [2], m_lapv [2];
    bit m_prev [2][4];

    int tests = 0;
    int fails = 0;

    function automatic int div_of(input int d);
        return (d == 0) ? DIV_UP : DIV_DN;
    endfunction

    function automatic int exp_state(input int d);
        if (m_done[d])  return 4;
        if (m_lap[d])   return 3;
        if (m_pause[d]) return 2;
        if (m_run[d])   return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_lap[d] = 0; m_pause[d] = 0; m_done[d] = 0;
            m_cnt[d] = 0; m_pre[d] = 0; m_lapv[d] = 0;
            for (int b = 0; b < 4; b++) m_prev[d][b] = 1;
        end
    endtask

    // One clock edge of behaviour, from the buttons seen in the closing cycle.
    task automatic model_step(input int d);
        bit p [4];
        bit on, tk, term;
        int old, act;
        for (int b = 0; b < 4; b++) begin
            p[b] = btn[d][b] && !m_prev[d][b];
            m_prev[d][b] = btn[d][b];
        end
        on   = m_run[d] || m_lap[d];
        tk   = on && (m_pre[d] == div_of(d) - 1);
        old  = m_cnt[d];
        term = 0;
        if (p[BTN_CLEAR]) begin
            m_run[d] = 0; m_lap[d] = 0; m_pause[d] = 0; m_done[d] = 0;
            m_pre[d] = 0;
            m_cnt[d] = (d == 1) ? int'(preset[d]) : 0;
        end else begin
            if (on) m_pre[d] = tk ? 0 : m_pre[d] + 1;
            if (tk) begin
                if (d == 1) begin
                    m_cnt[d] = m_cnt[d] - 1;
                    term = (m_cnt[d] == 0);
                end else begin
                    m_cnt[d] = (m_cnt[d] == MAXC) ? 0 : m_cnt[d] + 1;
                end
            end
            // 0 none, 1 stop, 2 lap, 3 start
            if (p[BTN_START] && p[BTN_STOP]) act = 0;
            else if (p[BTN_STOP])            act = 1;
            else if (p[BTN_LAP])             act = 2;
            else if (p[BTN_START])           act = 3;
            else                             act = 0;
            if (term) begin
                m_run[d] = 0; m_lap[d] = 0; m_done[d] = 1;
            end else if (m_run[d]) begin
                if (act == 1) begin m_run[d] = 0; m_pause[d] = 1; end
                else if (act == 2) begin m_run[d] = 0; m_lap[d] = 1; m_lapv[d] = old; end
            end else if (m_lap[d]) begin
                if (act == 1) begin m_lap[d] = 0; m_pause[d] = 1; end
                else if (act == 2) begin m_lap[d] = 0; m_run[d] = 1; end
            end else if (m_pause[d]) begin
                if (act == 3) begin m_pause[d] = 0; m_run[d] = 1; end
            end else if (!m_done[d]) begin
                if (act == 3) begin
                    if (d == 1 && m_cnt[d] == 0) m_done[d] = 1;
                    else                         m_run[d] = 1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit on;
        for (int d = 0; d < 2; d++) begin
            on = m_run[d] || m_lap[d];
            check($sformatf("d%0d_en", d),    32'(en_w[d]),    32'(on));
            check($sformatf("d%0d_count", d), 32'(count_w[d]), 32'(m_cnt[d]));
            check($sformatf("d%0d_disp", d),  32'(disp_w[d]),  32'(m_lap[d] ? m_lapv[d] : m_cnt[d]));
            check($sformatf("d%0d_tick", d),  32'(tick_w[d]),  32'(on && m_pre[d] == div_of(d) - 1));
            check($sformatf("d%0d_done", d),  32'(done_w[d]),  32'(m_done[d]));
            check($sformatf("d%0d_state", d), 32'(st_w[d]),    32'(exp_state(d)));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input int d, input int b);
        btn[d][b] = 1'b1;
        cyc();
        btn[d][b] = 1'b0;
        cyc();
    endtask

    task automatic wait_cnt(input int d, input int val, input int limit);
        int n = 0;
        while (m_cnt[d] != val && n < limit) begin
            cyc();
            n++;
        end
        check($sformatf("d%0d_reach_%0d", d, val), 32'(count_w[d]), 32'(val));
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        check("areset_en", 32'(en_w[0]), 32'd0);
        check("areset_count", 32'(count_w[0]), 32'd0);
        check("areset_state", 32'(st_w[0]), 32'd0);
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int frozen;
        btn[0] = '0; btn[1] = '0;
        preset[0] = 8'd0; preset[1] = 8'd3;
        model_reset();
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // start+stop together from IDLE: no transition
        btn[0] = 4'b0011;
        cyc();
        btn[0] = '0;
        cyc();
        check("ss_idle_state", 32'(st_w[0]), 32'd0);

        // up mode: 48 cycles after the press edge -> 12 steps, wraps past 9 to 2
        press(0, BTN_START);
        check("start_en", 32'(en_w[0]), 32'd1);
        repeat (47) cyc();
        check("wrap_count", 32'(count_w[0]), 32'd2);
        check("wrap_done", 32'(done_w[0]), 32'd0);

        // lap hold and release
        wait_cnt(0, 5, 100);
        press(0, BTN_LAP);
        wait_cnt(0, 8, 100);
        check("lap_hold", 32'(disp_w[0]), 32'd5);
        btn[0][BTN_LAP] = 1'b1;
        cyc();
        btn[0][BTN_LAP] = 1'b0;
        check("lap_exit_disp", 32'(disp_w[0]), 32'(m_cnt[0]));
        cyc();
        press(0, BTN_LAP);
        press(0, BTN_STOP);
        check("lap_stop_state", 32'(st_w[0]), 32'd2);
        check("lap_stop_disp", 32'(disp_w[0]), 32'(m_cnt[0]));

        // pause with pre=2, hold 20 cycles, resume: tick on second cycle after en
        press(0, BTN_START);
        n = 0;
        while (m_pre[0] != 1 && n < 20) begin cyc(); n++; end
        btn[0][BTN_STOP] = 1'b1;
        cyc();
        btn[0][BTN_STOP] = 1'b0;
        frozen = m_cnt[0];
        repeat (20) cyc();
        check("pause_frozen", 32'(count_w[0]), 32'(frozen));
        btn[0][BTN_START] = 1'b1;
        cyc();
        btn[0][BTN_START] = 1'b0;
        check("resume_first", 32'(tick_w[0]), 32'd0);
        cyc();
        check("resume_tick", 32'(tick_w[0]), 32'd1);

        // clear+start in one cycle: IDLE, count cleared
        btn[0] = 4'b1001;
        cyc();
        btn[0] = '0;
        check("clr_start_state", 32'(st_w[0]), 32'd0);
        check("clr_start_count", 32'(count_w[0]), 32'd0);
        cyc();

        // countdown 3,2,1,0 -> DONE; start ignored; clear reloads
        press(1, BTN_CLEAR);
        check("dn_load", 32'(count_w[1]), 32'd3);
        press(1, BTN_START);
        n = 0;
        while (!m_done[1] && n < 50) begin cyc(); n++; end
        check("dn_state", 32'(st_w[1]), 32'd4);
        check("dn_done", 32'(done_w[1]), 32'd1);
        check("dn_zero", 32'(count_w[1]), 32'd0);
        press(1, BTN_START);
        check("dn_start_ignored", 32'(st_w[1]), 32'd4);
        press(1, BTN_CLEAR);
        check("dn_reload", 32'(count_w[1]), 32'd3);
        check("dn_done_drop", 32'(done_w[1]), 32'd0);

        // async reset mid-RUN at count 7
        press(0, BTN_START);
        wait_cnt(0, 7, 100);
        async_reset_check();
        cyc();

        // countdown at count 0 after reset, start -> DONE
        press(1, BTN_START);
        check("dn_zero_start", 32'(st_w[1]), 32'd4);

        // start held through reset release: no RUN until released and re-pressed
        btn[0][BTN_START] = 1'b1;
        rst = 1'b1;
        model_reset();
        repeat (2) cyc();
        rst = 1'b0;
        repeat (3) cyc();
        check("held_start", 32'(st_w[0]), 32'd0);
        btn[0][BTN_START] = 1'b0;
        cyc();
        press(0, BTN_START);
        check("held_repress", 32'(st_w[0]), 32'd1);

        // randomized phase
        for (int i = 0; i < 800; i++) begin
            for (int d = 0; d < 2; d++) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, (b == BTN_CLEAR) ? 60 : 7) == 0)
                        btn[d][b] = ~btn[d][b];
                end
                if ($urandom_range(0, 30) == 0) preset[d] = W'($urandom_range(0, 5));
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Parametrised stopwatch controller: button-driven run/pause state machine plus the time-base prescaler and elapsed-time counter it gates. It adds lap hold, synchronous clear, countdown mode with terminal detection, and internal press (rising-edge) detection. It sits between the debounced button synchronisers and the display driver, and replaces the bare start/stop enable FSM.

## Interface
- CNT_W, 16, width of count, display and preset values.
- TICK_DIV, 1000, clk cycles per count step; legal range ≥1, and 1 means a step every enabled cycle.
- COUNT_DOWN, 0, selects the mode: 0 counts up with wrap, 1 counts down from preset and stops at zero.
- MAX_COUNT, 2**CNT_W-1, up-mode wrap limit; must be ≤2**CNT_W-1; ignored when COUNT_DOWN=1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  debounced level; only its rising edge acts.
- stop  in  1  debounced level; only its rising edge acts.
- lap  in  1  debounced level; only its rising edge acts.
- clear  in  1  debounced level; only its rising edge acts.
- preset  in  CNT_W  countdown load value, sampled on a clear press.
- en  out  1  high in RUN and LAP.
- count  out  CNT_W  live elapsed or remaining value.
- disp  out  CNT_W  display value; equals count except in LAP, where it holds the lap snapshot.
- tick  out  1  one-cycle pulse in the cycle whose closing edge steps count.
- done  out  1  countdown terminal flag; held until clear or reset.
- state_o  out  3  current state encoding, for debug.

## Operation
- Press detection: press_x = x & ~x_q, where x_q is the previous-cycle sample. x_q resets to 1, so a button held through reset does not act until it is released and pressed again.
- States:
  - IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4.
  - Reset value is IDLE.
  - Unused encodings go to IDLE.
- Press priority within one cycle: clear > start&stop together (ignored) > stop > lap > start.
- Clear press, from any state:
  - state goes to IDLE; the prescaler goes to 0; done goes to 0.
  - count loads preset when COUNT_DOWN=1, else 0.
- IDLE:
  - start goes to RUN.
  - In countdown, start with count==0 goes to DONE.
- RUN:
  - stop goes to PAUSE.
  - lap goes to LAP and snapshots count into the lap register.
  - The countdown terminal step goes to DONE.
- LAP:
  - Counting continues.
  - lap goes to RUN and disp follows count again.
  - stop goes to PAUSE and disp follows count.
  - The terminal step goes to DONE.
- PAUSE:
  - start goes to RUN; lap is ignored.
  - The prescaler holds its value, so a partial tick resumes where it stopped.
- DONE: only clear or reset exits; en=0; count holds 0.
- Prescaler:
  - Width is max(1, $clog2(TICK_DIV)).
  - Increments while en=1.
  - tick = en & (pre == TICK_DIV-1); on tick, pre wraps to 0.
- Count step on tick:
  - Up mode: count==MAX_COUNT ? 0 : count+1. Wrap is silent and sets no flag.
  - Down mode: count-1. The step from 1 to 0 sets done and enters DONE on the same edge.
  - In down mode, a tick with count already 0 is impossible (the state would be DONE).
- Reset values: en 0, count 0, disp 0, lap register 0, tick 0, done 0, state_o 0, pre 0.
- Reset mid-run forces all of these values asynchronously. preset is not reloaded by reset.

## Timing
- A press is recognised in the cycle where the input is first seen high.
- State, count load and the lap snapshot update on that cycle's closing edge, so outputs reflect the press one cycle later.
- en, state_o, disp and done are pure register decodes; none has a combinational path from an input.
- tick is a registered-state decode. It is high for exactly one cycle per TICK_DIV enabled cycles, and count changes on that cycle's closing edge.
- The first tick after a start press from IDLE with pre=0 occurs TICK_DIV cycles after en rises.
- Every other button pressed in the same cycle as clear is discarded.

## Structure
- Package stopwatch_pkg:
  - state_t enum with the encodings above.
  - Button index constants BTN_START=0, BTN_STOP=1, BTN_LAP=2, BTN_CLEAR=3.
- Sub-module btn_edge:
  - Parametrised width-W rising-edge detector with an async reset-to-ones sample register.
  - Instantiated once with W=4.
- Top level contains: the FSM (two processes, registered state and combinational next-state), the prescaler, the counter, the lap register and the output decode.

## Test plan
- Up mode, TICK_DIV=4, CNT_W=8, MAX_COUNT=9:
  - Stimulus: start pulse, then run 48 cycles.
  - Required: en rises one cycle after the press; tick pulses every 4th cycle; count goes 0..9, wraps to 0 and reaches 2; done stays 0.
- Lap: in RUN at count=5, press lap.
  - Required: disp holds 5 while count keeps advancing to 8.
  - Pressing lap again makes disp equal count on the next cycle.
  - Pressing stop while in LAP goes to PAUSE, and disp equals count.
- Pause and resume: stop at pre=2, wait 20 cycles, then press start.
  - Required: count is frozen during the pause; the first tick comes 2 cycles after en re-rises.
- Countdown, COUNT_DOWN=1, preset=3, TICK_DIV=2:
  - Stimulus: press clear, then start.
  - Required: count steps 3, 2, 1, 0; done and state DONE are asserted on the 1→0 edge; a later start is ignored; clear reloads 3 and drops done.
- Simultaneous presses and reset edge cases:
  - start+stop in one cycle from IDLE: no transition.
  - clear+start in one cycle: IDLE with count cleared.
  - start held through reset release: no RUN until the button is released and pressed again.
  - Countdown with count=0 after reset, then start: goes to DONE.
- Async reset mid-RUN at count=7: all outputs are 0 and the state is IDLE before the next clk edge.
